// File: rtl/mux3_rr_arbiter.sv
// Three-requester burst arbiter with a registered output stage; a grant is held until the last beat.
// Define MUX3_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority 0 > 1 > 2.
module mux3_rr_arbiter #(
  parameter int unsigned DWidth = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        req_valid_i,
  input  logic [2:0]        req_last_i,
  input  logic [DWidth-1:0] data0_i,
  input  logic [DWidth-1:0] data1_i,
  input  logic [DWidth-1:0] data2_i,
  output logic [2:0]        req_ready_o,
  output logic              out_valid_o,
  output logic [DWidth-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [1:0]        select_o,
  output logic [2:0]        grant_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        grant_q, grant_d;
  logic              out_valid_q, out_valid_d;
  logic [DWidth-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              win_any;
  logic [1:0]        win_sel;
  logic              g_valid, g_last;
  logic [DWidth-1:0] g_data;
  logic              ready_c;
  logic              accept;

`ifndef MUX3_ARB_FIXED_PRIO_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand0, cand1, cand2;

  // Modulo-3 successor; ptr never holds 3.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
`endif

  // Pick the IDLE winner
  always_comb begin
    win_any = |req_valid_i;
    win_sel = 2'd0;
`ifdef MUX3_ARB_FIXED_PRIO_EN
    if (req_valid_i[0])      win_sel = 2'd0;
    else if (req_valid_i[1]) win_sel = 2'd1;
    else if (req_valid_i[2]) win_sel = 2'd2;
`else
    cand0 = inc3(ptr_q);
    cand1 = inc3(cand0);
    cand2 = ptr_q;
    if (req_valid_i[cand0])      win_sel = cand0;
    else if (req_valid_i[cand1]) win_sel = cand1;
    else if (req_valid_i[cand2]) win_sel = cand2;
`endif
  end

  // Granted requester's beat
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    case (sel_q)
      2'd0: begin g_valid = req_valid_i[0]; g_last = req_last_i[0]; g_data = data0_i; end
      2'd1: begin g_valid = req_valid_i[1]; g_last = req_last_i[1]; g_data = data1_i; end
      2'd2: begin g_valid = req_valid_i[2]; g_last = req_last_i[2]; g_data = data2_i; end
      default: ;
    endcase
  end

  // Output register can take a beat when empty or draining this edge
  assign ready_c     = (state_q == LOCKED) && (!out_valid_q || out_ready_i);
  assign accept      = ready_c && g_valid;
  assign req_ready_o = ready_c ? grant_q : 3'b000;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifndef MUX3_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_last_d  = g_last;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = LOCKED;
          sel_d   = win_sel;
          case (win_sel)
            2'd0:    grant_d = 3'b001;
            2'd1:    grant_d = 3'b010;
            default: grant_d = 3'b100;
          endcase
        end
      end
      LOCKED: begin
        if (accept && g_last) begin
          state_d = IDLE;
          sel_d   = 2'd0;
          grant_d = 3'b000;
`ifndef MUX3_ARB_FIXED_PRIO_EN
          ptr_d   = sel_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      grant_q     <= 3'b000;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

`ifndef MUX3_ARB_FIXED_PRIO_EN
  // ptr resets to 2 so requester 0 wins first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 2'd2;
    else       ptr_q <= ptr_d;
  end
`endif

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign select_o    = sel_q;
  assign grant_o     = grant_q;

endmodule
